// File: rtl/fpu_taylor_seq.sv
// fpu_taylor_seq: Horner-rule sequencer for truncated Taylor kernels.
// Walks the 1/k! coefficient ROM from the highest index down to the lowest,
// issuing acc*y + coef to the shared fused multiply-add unit for each term.
// Words are {Sign, Exp[7:0], Mant[27:0]}; ROM words carry no sign, so the
// sequencer attaches the alternating sign itself.
module fpu_taylor_seq #(
  parameter int CAddrLen = 6,
  parameter int CWordLen = 37
) (
  input  logic                AClkH,
  input  logic                AResetHN,
  input  logic                AReq,
  input  logic [CWordLen-1:0] AArg,
  input  logic [CAddrLen-1:0] AIdxHi,
  input  logic [CAddrLen-1:0] AIdxLo,
  input  logic                AStep2,
  input  logic                ANegAlt,
  output logic                ABusy,
  output logic                ARdy,
  output logic                AErr,
  output logic [CWordLen-1:0] AResult,
  output logic [CAddrLen-1:0] ACoefAddr,
  input  logic [CWordLen-2:0] ACoefData,
  output logic                AMacReq,
  output logic [CWordLen-1:0] AMacA,
  output logic [CWordLen-1:0] AMacB,
  output logic [CWordLen-1:0] AMacC,
  input  logic                AMacAck,
  input  logic                AMacVld,
  input  logic [CWordLen-1:0] AMacRes
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t              r_state;
  logic [CWordLen-1:0] r_y;
  logic [CWordLen-1:0] r_acc;
  logic [CWordLen-1:0] r_result;
  logic [CAddrLen-1:0] r_addr;
  logic [CAddrLen-1:0] r_lo;
  logic                r_step2;
  logic                r_negalt;
  logic                r_par;
  logic                r_bad;
  logic                r_err;
  logic                r_busy;
  logic                r_rdy;
  logic                r_macreq;

  logic [CAddrLen-1:0] w_step;
  logic [CAddrLen:0]   w_lim;
  logic                w_last;
  logic [CAddrLen-1:0] w_addr_nxt;
  logic [CWordLen-1:0] w_coef_sgn;
  logic [1:0]          w_diff_lo;
  logic                w_req_par;
  logic                w_bad;

  // Index stride: odd/even series skip every other coefficient.
  assign w_step     = r_step2 ? CAddrLen'(2) : CAddrLen'(1);

  // The last term is reached once another step would pass below the low
  // index; compared one bit wider so lo + step cannot wrap.
  assign w_lim      = {1'b0, r_lo} + {1'b0, w_step};
  assign w_last     = ({1'b0, r_addr} < w_lim);
  assign w_addr_nxt = r_addr - w_step;

  // Coefficient with its alternating sign applied. The parity bit starts at
  // the term count's LSB so that the term at the low index comes out positive.
  assign w_coef_sgn = {r_negalt & r_par, ACoefData};

  // Only bit 0 of the term count is needed; the low two bits of hi - lo
  // depend only on the low two bits of the operands.
  assign w_diff_lo  = AIdxHi[1:0] - AIdxLo[1:0];
  assign w_req_par  = AStep2 ? w_diff_lo[1] : w_diff_lo[0];
  assign w_bad      = (AIdxHi < AIdxLo);

  assign ABusy      = r_busy;
  assign ARdy       = r_rdy;
  assign AErr       = r_err;
  assign AResult    = r_result;
  assign ACoefAddr  = r_addr;
  assign AMacReq    = r_macreq;
  assign AMacA      = r_acc;
  assign AMacB      = r_y;
  // The addend comes straight from the ROM at the current address, which is
  // frozen while the request is up, so it is as stable as the registers.
  assign AMacC      = r_macreq ? w_coef_sgn : '0;

  // Sequencer: request capture, coefficient load, MAC issue/wait, completion.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_state  <= ST_IDLE;
      r_y      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_addr   <= '0;
      r_lo     <= '0;
      r_step2  <= 1'b0;
      r_negalt <= 1'b0;
      r_par    <= 1'b0;
      r_bad    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_rdy    <= 1'b0;
      r_macreq <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (AReq) begin
            r_y      <= AArg;
            r_lo     <= AIdxLo;
            r_step2  <= AStep2;
            r_negalt <= ANegAlt;
            r_addr   <= AIdxHi;
            r_par    <= w_req_par;
            r_bad    <= w_bad;
            r_busy   <= 1'b1;
            r_state  <= w_bad ? ST_DONE : ST_LOAD;
          end
        end

        ST_LOAD: begin
          // Highest-order coefficient seeds the accumulator.
          r_acc <= w_coef_sgn;
          r_par <= ~r_par;
          if (w_last) begin
            r_state <= ST_DONE;
          end else begin
            r_addr   <= w_addr_nxt;
            r_macreq <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // Results arriving here belong to nobody and are dropped.
          if (AMacAck) begin
            r_macreq <= 1'b0;
            r_state  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (AMacVld) begin
            r_acc <= AMacRes;
            r_par <= ~r_par;
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_addr   <= w_addr_nxt;
              r_macreq <= 1'b1;
              r_state  <= ST_ISSUE;
            end
          end
        end

        ST_DONE: begin
          r_rdy    <= 1'b1;
          r_err    <= r_bad;
          r_result <= r_bad ? '0 : r_acc;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_macreq <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_taylor_seq.sv
// Testbench for fpu_taylor_seq: ROM model, stub MAC with configurable ack
// delay and latency, and a Horner reference model over the coefficient list.
module tb_fpu_taylor_seq;

  logic        AClkH;
  logic        AResetHN;
  logic        AReq;
  logic [36:0] AArg;
  logic [5:0]  AIdxHi;
  logic [5:0]  AIdxLo;
  logic        AStep2;
  logic        ANegAlt;
  logic        ABusy;
  logic        ARdy;
  logic        AErr;
  logic [36:0] AResult;
  logic [5:0]  ACoefAddr;
  logic [35:0] ACoefData;
  logic        AMacReq;
  logic [36:0] AMacA;
  logic [36:0] AMacB;
  logic [36:0] AMacC;
  logic        AMacAck;
  logic        AMacVld;
  logic [36:0] AMacRes;

  int n_vec = 0;
  int n_err = 0;

  logic [35:0] rom_tab [0:63];
  assign ACoefData = rom_tab[ACoefAddr];

  // MAC stub configuration and operation log
  int          mac_lat = 2;
  int          ack_dly = 0;
  int          inj_req = 0;
  int          unstable = 0;
  logic [36:0] log_a[$];
  logic [36:0] log_b[$];
  logic [36:0] log_c[$];
  logic [36:0] log_r[$];
  int          log_addr[$];

  // Reference model outputs
  logic [36:0] exp_a[$];
  logic [36:0] exp_c[$];
  int          exp_addr[$];

  fpu_taylor_seq #(.CAddrLen(6), .CWordLen(37)) dut (
    .AClkH(AClkH), .AResetHN(AResetHN), .AReq(AReq), .AArg(AArg),
    .AIdxHi(AIdxHi), .AIdxLo(AIdxLo), .AStep2(AStep2), .ANegAlt(ANegAlt),
    .ABusy(ABusy), .ARdy(ARdy), .AErr(AErr), .AResult(AResult),
    .ACoefAddr(ACoefAddr), .ACoefData(ACoefData),
    .AMacReq(AMacReq), .AMacA(AMacA), .AMacB(AMacB), .AMacC(AMacC),
    .AMacAck(AMacAck), .AMacVld(AMacVld), .AMacRes(AMacRes)
  );

  initial begin
    AClkH = 0;
    forever #5 AClkH = ~AClkH;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Stand-in for the fused multiply-add: any deterministic mix of operands.
  function automatic logic [36:0] mac_fn(input logic [36:0] a, input logic [36:0] b,
                                         input logic [36:0] c);
    return {a[35:0], a[36]} ^ (b + c);
  endfunction

  // MAC stub: acks after ack_dly waiting cycles, returns a result mac_lat
  // cycles after acceptance, records accepted operands and operand stability.
  initial begin : mac_model
    logic        req_prev, ack_prev;
    int          pend, wcnt, inj_done;
    logic [36:0] pres, ca, cb, cc;
    logic [5:0]  cad;
    req_prev = 0; ack_prev = 0; pend = 0; wcnt = 0; inj_done = 0;
    pres = '0; ca = '0; cb = '0; cc = '0; cad = '0;
    AMacAck = 0; AMacVld = 0; AMacRes = '0;
    forever begin
      @(posedge AClkH); #2;
      AMacVld = 0;
      AMacAck = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin AMacVld = 1; AMacRes = pres; end
      end
      if (req_prev && ack_prev) begin
        log_a.push_back(ca); log_b.push_back(cb); log_c.push_back(cc);
        log_addr.push_back(int'(cad));
        pres = mac_fn(ca, cb, cc);
        log_r.push_back(pres);
        if (mac_lat <= 1) begin AMacVld = 1; AMacRes = pres; end
        else pend = mac_lat - 1;
        wcnt = 0;
      end
      if (inj_req != inj_done) begin
        AMacVld = 1;
        AMacRes = 37'h1_2345_6789;
        inj_done = inj_req;
      end
      if (AMacReq) begin
        if (req_prev && !ack_prev) begin
          if (AMacA !== ca || AMacB !== cb || AMacC !== cc || ACoefAddr !== cad) unstable++;
        end else begin
          ca = AMacA; cb = AMacB; cc = AMacC; cad = ACoefAddr;
        end
        if (wcnt >= ack_dly) AMacAck = 1;
        else wcnt++;
      end
      req_prev = AMacReq;
      ack_prev = AMacAck;
    end
  end

  // Horner reference: coefficient list from hi down by the stride, signs
  // alternating so the term at the end of the list is positive.
  task automatic model_op(input logic [5:0] hi_i, input logic [5:0] lo_i, input logic s2,
                          input logic neg, input logic [36:0] y,
                          output logic [36:0] res, output logic err, output int nops);
    int hi, lo, s, n, a, k;
    logic [36:0] acc, c;
    exp_a.delete(); exp_c.delete(); exp_addr.delete();
    hi = int'(hi_i); lo = int'(lo_i);
    s = s2 ? 2 : 1;
    nops = 0;
    if (hi < lo) begin
      err = 1; res = '0;
      return;
    end
    err = 0;
    n = (hi - lo) / s;
    acc = {neg && (n % 2 == 1), rom_tab[hi]};
    a = hi; k = 0;
    while (a >= lo + s) begin
      a -= s; k++;
      c = {neg && ((n - k) % 2 == 1), rom_tab[a]};
      exp_a.push_back(acc); exp_c.push_back(c); exp_addr.push_back(a);
      acc = mac_fn(acc, y, c);
    end
    nops = k;
    res = acc;
  endtask

  // Drive one request (held until ABusy) and wait, bounded, for ARdy.
  task automatic run_op(input logic [5:0] hi, input logic [5:0] lo, input logic s2,
                        input logic neg, input logic [36:0] y, input bit spur,
                        output int cyc, output logic [36:0] res, output logic err,
                        output bit to, output logic busy1);
    bit spur_done;
    spur_done = 0;
    @(posedge AClkH); #1;
    AReq = 1; AArg = y; AIdxHi = hi; AIdxLo = lo; AStep2 = s2; ANegAlt = neg;
    cyc = 0; to = 1; busy1 = 0; res = '0; err = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge AClkH); #1;
      cyc++;
      if (cyc == 1) busy1 = ABusy;
      if (ABusy) AReq = 0;
      if (spur && !spur_done && AMacReq) begin inj_req++; spur_done = 1; end
      if (ARdy) begin to = 0; res = AResult; err = AErr; break; end
    end
    AReq = 0;
  endtask

  task automatic test_reset();
    AResetHN = 1; #2;
    AResetHN = 0;
    repeat (3) @(posedge AClkH);
    #1;
    n_vec++; if ({ABusy, ARdy, AErr, AMacReq} !== 4'b0) begin n_err++;
      $display("FAIL reset_ctl: busy/rdy/err/req got %b want 0000", {ABusy, ARdy, AErr, AMacReq}); end
    n_vec++; if (AResult !== 37'h0) begin n_err++;
      $display("FAIL reset_result: got %h want 0", AResult); end
    n_vec++; if ({AMacA, AMacB, AMacC} !== 111'h0) begin n_err++;
      $display("FAIL reset_macops: got %h %h %h want 0", AMacA, AMacB, AMacC); end
    n_vec++; if (ACoefAddr !== 6'h0) begin n_err++;
      $display("FAIL reset_addr: got %h want 0", ACoefAddr); end
    #3 AResetHN = 1;
    @(posedge AClkH); #1;
    n_vec++; if (ABusy !== 1'b0) begin n_err++;
      $display("FAIL reset_idle_busy: got %b want 0", ABusy); end
  endtask

  task automatic test_single_term();
    int cyc, base; logic [36:0] r; logic e, b1; bit to;
    ack_dly = 0; mac_lat = 2; base = log_a.size();
    run_op(6'd1, 6'd1, 1'b0, 1'b0, 37'h0_1234_5678, 0, cyc, r, e, to, b1);
    n_vec++; if (to) begin n_err++; $display("FAIL single_timeout: no ARdy within bound"); end
    n_vec++; if (cyc != 3) begin n_err++; $display("FAIL single_latency: got %0d want 3", cyc); end
    n_vec++; if (r !== {1'b0, 8'h7F, 28'h8000000}) begin n_err++;
      $display("FAIL single_result: got %h want %h", r, {1'b0, 8'h7F, 28'h8000000}); end
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", e); end
    n_vec++; if (b1 !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", b1); end
    n_vec++; if (log_a.size() != base) begin n_err++;
      $display("FAIL single_nops: got %0d want 0", log_a.size() - base); end
  endtask

  task automatic test_exp_tail();
    int cyc, base; logic [36:0] r, y; logic e, b1; bit to;
    ack_dly = 0; mac_lat = 2; base = log_a.size();
    y = {1'b0, 8'h7F, 28'h8000000};
    run_op(6'd3, 6'd1, 1'b0, 1'b0, y, 0, cyc, r, e, to, b1);
    n_vec++; if (to) begin n_err++; $display("FAIL exp_timeout: no ARdy within bound"); end
    n_vec++; if (log_a.size() - base != 2) begin n_err++;
      $display("FAIL exp_nops: got %0d want 2", log_a.size() - base); end
    else begin
      n_vec++; if (log_a[base] !== {1'b0, 8'h7C, 28'hAAAAAAA} || log_b[base] !== y
                   || log_c[base] !== {1'b0, 8'h7E, 28'h8000000}) begin n_err++;
        $display("FAIL exp_op0: got A=%h B=%h C=%h want A=%h B=%h C=%h", log_a[base], log_b[base],
                 log_c[base], {1'b0, 8'h7C, 28'hAAAAAAA}, y, {1'b0, 8'h7E, 28'h8000000}); end
      n_vec++; if (log_a[base+1] !== log_r[base] || log_c[base+1] !== {1'b0, 8'h7F, 28'h8000000}) begin
        n_err++; $display("FAIL exp_op1: got A=%h C=%h want A=%h C=%h", log_a[base+1], log_c[base+1],
                          log_r[base], {1'b0, 8'h7F, 28'h8000000}); end
      n_vec++; if (r !== log_r[base+1]) begin n_err++;
        $display("FAIL exp_result: got %h want %h", r, log_r[base+1]); end
    end
    n_vec++; if (cyc != 9) begin n_err++; $display("FAIL exp_latency: got %0d want 9", cyc); end
  endtask

  task automatic test_sin_series();
    int cyc, base, en; logic [36:0] r, y, er; logic e, b1, ee; bit to;
    int  want_addr [3];
    bit  want_sgn [3];
    want_addr = '{5, 3, 1};
    want_sgn  = '{0, 1, 0};
    ack_dly = 1; mac_lat = 3; base = log_a.size();
    y = {5'($urandom_range(0, 31)), $urandom()};
    model_op(6'd7, 6'd1, 1'b1, 1'b1, y, er, ee, en);
    run_op(6'd7, 6'd1, 1'b1, 1'b1, y, 0, cyc, r, e, to, b1);
    n_vec++; if (to) begin n_err++; $display("FAIL sin_timeout: no ARdy within bound"); end
    n_vec++; if (log_a.size() - base != 3) begin n_err++;
      $display("FAIL sin_nops: got %0d want 3", log_a.size() - base); end
    else begin
      n_vec++; if (log_a[base][36] !== 1'b1 || log_a[base][35:0] !== rom_tab[7]) begin n_err++;
        $display("FAIL sin_load: got %h want sign 1 coef %h", log_a[base], rom_tab[7]); end
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (log_addr[base+i] != want_addr[i] || log_c[base+i][36] !== want_sgn[i]) begin
          n_err++; $display("FAIL sin_op%0d: got addr %0d sign %b want addr %0d sign %b", i,
                            log_addr[base+i], log_c[base+i][36], want_addr[i], want_sgn[i]); end
      end
    end
    n_vec++; if (r !== er) begin n_err++; $display("FAIL sin_result: got %h want %h", r, er); end
    n_vec++; if (cyc != 3 + 3 * (1 + 3 + 1)) begin n_err++;
      $display("FAIL sin_latency: got %0d want %0d", cyc, 3 + 3 * 5); end
  endtask

  task automatic test_backpressure();
    int cyc, base, en, ust; logic [36:0] r, y, er; logic e, b1, ee; bit to;
    ack_dly = 5; mac_lat = 2; base = log_a.size(); ust = unstable;
    y = {5'($urandom_range(0, 31)), $urandom()};
    model_op(6'd4, 6'd1, 1'b0, 1'b1, y, er, ee, en);
    run_op(6'd4, 6'd1, 1'b0, 1'b1, y, 1, cyc, r, e, to, b1);
    n_vec++; if (to) begin n_err++; $display("FAIL bp_timeout: no ARdy within bound"); end
    n_vec++; if (unstable != ust) begin n_err++;
      $display("FAIL bp_stable: got %0d operand changes while stalled want 0", unstable - ust); end
    n_vec++; if (r !== er) begin n_err++; $display("FAIL bp_result: got %h want %h", r, er); end
    n_vec++; if (log_a.size() - base != en) begin n_err++;
      $display("FAIL bp_nops: got %0d want %0d", log_a.size() - base, en); end
    else for (int i = 0; i < en; i++) begin
      n_vec++; if (log_a[base+i] !== exp_a[i] || log_c[base+i] !== exp_c[i]) begin n_err++;
        $display("FAIL bp_op%0d: got A=%h C=%h want A=%h C=%h", i, log_a[base+i], log_c[base+i],
                 exp_a[i], exp_c[i]); end
    end
    n_vec++; if (cyc != 3 + en * (5 + 2 + 1)) begin n_err++;
      $display("FAIL bp_latency: got %0d want %0d", cyc, 3 + en * 8); end
  endtask

  task automatic test_error_overlap();
    int cyc, base, en, rdy_cnt; logic [36:0] r, y, er, rr; logic e, b1, ee; bit to, up;
    ack_dly = 0; mac_lat = 2; base = log_a.size();
    y = {5'($urandom_range(0, 31)), $urandom()};
    run_op(6'd2, 6'd5, 1'b0, 1'b0, y, 0, cyc, r, e, to, b1);
    n_vec++; if (to) begin n_err++; $display("FAIL err_timeout: no ARdy within bound"); end
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL err_flag: got %b want 1", e); end
    n_vec++; if (r !== 37'h0) begin n_err++; $display("FAIL err_result: got %h want 0", r); end
    n_vec++; if (log_a.size() != base) begin n_err++;
      $display("FAIL err_nops: got %0d want 0", log_a.size() - base); end

    ack_dly = 3; mac_lat = 3;
    model_op(6'd4, 6'd2, 1'b0, 1'b1, y, er, ee, en);
    @(posedge AClkH); #1;
    AReq = 1; AArg = y; AIdxHi = 6'd4; AIdxLo = 6'd2; AStep2 = 0; ANegAlt = 1;
    up = 0;
    for (int i = 0; i < 5 && !up; i++) begin
      @(posedge AClkH); #1;
      up = ABusy;
    end
    n_vec++; if (!up) begin n_err++; $display("FAIL ovl_busy: got ABusy 0 want 1"); end
    AArg = ~y; AIdxHi = 6'd9; AIdxLo = 6'd0; AStep2 = 1;
    rdy_cnt = 0; rr = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge AClkH); #1;
      if (i == 6) AReq = 0;
      if (ARdy) begin rdy_cnt++; rr = AResult; end
    end
    AReq = 0;
    n_vec++; if (rdy_cnt != 1) begin n_err++; $display("FAIL ovl_rdy_count: got %0d want 1", rdy_cnt); end
    n_vec++; if (rr !== er) begin n_err++; $display("FAIL ovl_result: got %h want %h", rr, er); end
  endtask

  task automatic test_reset_mid();
    int cyc, en; logic [36:0] r, y, er; logic e, b1, ee; bit to, seen, inwait, bad;
    ack_dly = 0; mac_lat = 6;
    y = {5'($urandom_range(0, 31)), $urandom()};
    @(posedge AClkH); #1;
    AReq = 1; AArg = y; AIdxHi = 6'd3; AIdxLo = 6'd0; AStep2 = 0; ANegAlt = 0;
    seen = 0; inwait = 0;
    for (int i = 0; i < 20 && !inwait; i++) begin
      @(posedge AClkH); #1;
      if (ABusy) AReq = 0;
      if (AMacReq) seen = 1;
      else if (seen && ABusy) inwait = 1;
    end
    AReq = 0;
    n_vec++; if (!inwait) begin n_err++; $display("FAIL rstmid_wait: got no WAIT phase want one"); end
    #2 AResetHN = 0;
    #1;
    n_vec++; if ({ABusy, ARdy, AErr, AMacReq} !== 4'b0) begin n_err++;
      $display("FAIL rstmid_ctl: busy/rdy/err/req got %b want 0000", {ABusy, ARdy, AErr, AMacReq}); end
    n_vec++; if ({AResult, AMacA, AMacB, AMacC, ACoefAddr} !== 154'h0) begin n_err++;
      $display("FAIL rstmid_data: got res=%h A=%h B=%h C=%h addr=%h want 0", AResult, AMacA, AMacB,
               AMacC, ACoefAddr); end
    #3 AResetHN = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge AClkH); #1;
      if (ABusy || ARdy || AResult !== 37'h0) bad = 1;
    end
    n_vec++; if (bad) begin n_err++; $display("FAIL rstmid_late_vld: got activity after reset want none"); end
    mac_lat = 2;
    model_op(6'd3, 6'd1, 1'b0, 1'b0, y, er, ee, en);
    run_op(6'd3, 6'd1, 1'b0, 1'b0, y, 0, cyc, r, e, to, b1);
    n_vec++; if (to || r !== er) begin n_err++;
      $display("FAIL rstmid_after: got %h (timeout %0d) want %h", r, to, er); end
  endtask

  task automatic test_random();
    int cyc, base, en; logic [36:0] r, y, er; logic e, b1, ee; bit to;
    logic [5:0] hi, lo, t; logic s2, neg;
    for (int k = 0; k < 25; k++) begin
      hi = 6'($urandom_range(0, 20));
      lo = 6'($urandom_range(0, 20));
      if (hi < lo && $urandom_range(0, 5) != 0) begin t = hi; hi = lo; lo = t; end
      s2 = 1'($urandom_range(0, 1));
      neg = 1'($urandom_range(0, 1));
      y = {5'($urandom_range(0, 31)), $urandom()};
      ack_dly = $urandom_range(0, 3);
      mac_lat = $urandom_range(1, 4);
      base = log_a.size();
      model_op(hi, lo, s2, neg, y, er, ee, en);
      run_op(hi, lo, s2, neg, y, 0, cyc, r, e, to, b1);
      n_vec++; if (to) begin n_err++;
        $display("FAIL rnd%0d_timeout: hi=%0d lo=%0d no ARdy within bound", k, hi, lo); continue; end
      n_vec++; if (e !== ee || r !== er) begin n_err++;
        $display("FAIL rnd%0d_result: hi=%0d lo=%0d s2=%b neg=%b got err=%b res=%h want err=%b res=%h",
                 k, hi, lo, s2, neg, e, r, ee, er); end
      n_vec++; if (log_a.size() - base != en) begin n_err++;
        $display("FAIL rnd%0d_nops: got %0d want %0d", k, log_a.size() - base, en); end
      else for (int i = 0; i < en; i++) begin
        n_vec++; if (log_a[base+i] !== exp_a[i] || log_b[base+i] !== y || log_c[base+i] !== exp_c[i]
                     || log_addr[base+i] != exp_addr[i]) begin n_err++;
          $display("FAIL rnd%0d_op%0d: got A=%h B=%h C=%h addr=%0d want A=%h B=%h C=%h addr=%0d", k, i,
                   log_a[base+i], log_b[base+i], log_c[base+i], log_addr[base+i], exp_a[i], y, exp_c[i],
                   exp_addr[i]); end
      end
      if (!ee) begin
        n_vec++; if (cyc != 3 + en * (ack_dly + mac_lat + 1)) begin n_err++;
          $display("FAIL rnd%0d_latency: got %0d want %0d", k, cyc, 3 + en * (ack_dly + mac_lat + 1)); end
      end
    end
  endtask

  initial begin
    AResetHN = 1; AReq = 0; AArg = '0; AIdxHi = '0; AIdxLo = '0; AStep2 = 0; ANegAlt = 0;
    // Coefficient ROM: word k holds 1/k!, addresses from 0x11 up read 1/0!.
    for (int a = 0; a < 64; a++) begin
      int  k, ex;
      real f;
      k = (a >= 17) ? 0 : a;
      f = 1.0;
      for (int i = 2; i <= k; i++) f = f / i;
      ex = 127;
      while (f < 1.0) begin f = f * 2.0; ex--; end
      rom_tab[a] = {8'(ex), 28'($rtoi(f * 134217728.0))};
    end
    test_reset();
    test_single_term();
    test_exp_tail();
    test_sin_series();
    test_backpressure();
    test_error_overlap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_taylor_seq.md
# fpu_taylor_seq

Sequencer that evaluates a truncated Taylor polynomial with Horner's rule. It fetches coefficients from the 1/k! coefficient ROM and issues multiply-add operations to the FPU's shared fused multiply-add (MAC) unit. It sits between the FPU instruction decoder, which issues exp/sin/cos kernel requests, and the MAC unit, which it owns while busy. Word format is 37 bits {Sign, Exp[7:0], Mant[27:0]}, with an explicit leading one in the mantissa, so 1.0 = {0, 8'h7F, 28'h8000000}. ROM words are 36-bit {Exp, Mant} and always positive.

## Interface
Parameters:
- CAddrLen, 6, coefficient ROM address width
- CWordLen, 37, FP word width {Sign, Exp[7:0], Mant[27:0]}

Ports:
- AClkH  in  1  clock; everything is sampled on the rising edge
- AResetHN  in  1  asynchronous active-low reset
- AReq  in  1  start request; sampled only in IDLE
- AArg  in  37  Horner variable y (caller passes x or x²)
- AIdxHi  in  6  highest coefficient index (first term evaluated)
- AIdxLo  in  6  lowest coefficient index (last term evaluated)
- AStep2  in  1  0: index step 1; 1: index step 2 (odd/even series)
- ANegAlt  in  1  alternate coefficient signs; the term at AIdxLo is positive
- ABusy  out  1  high in every state except IDLE
- ARdy  out  1  one-cycle completion pulse
- AErr  out  1  valid with ARdy; set when AIdxHi < AIdxLo
- AResult  out  37  polynomial value; valid with ARdy and held until the next ARdy
- ACoefAddr  out  6  ROM address
- ACoefData  in  36  ROM data, combinational from ACoefAddr in the same cycle
- AMacReq  out  1  MAC request; operands are A*B+C
- AMacA, AMacB, AMacC  out  37  MAC operands
- AMacAck  in  1  MAC accepted the operands this cycle
- AMacVld  in  1  MAC result valid (single-cycle pulse)
- AMacRes  in  37  MAC result

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE, with AReq=1:
  - Latch AArg, AIdxLo, AStep2 and ANegAlt.
  - Set the address register to AIdxHi.
  - Compute term count n = (AIdxHi−AIdxLo) >> AStep2 and set the parity bit to n[0].
  - If AIdxHi < AIdxLo, go to DONE with AErr=1 and result 0. Otherwise go to LOAD.
- LOAD:
  - acc ← {ANegAlt & parity, ACoefData}.
  - Toggle parity.
  - If addr < AIdxLo + step (a 7-bit compare, no wrap), go to DONE. Otherwise addr ← addr − step, then go to ISSUE.
- ISSUE:
  - AMacReq=1, AMacA=acc, AMacB=latched y, AMacC={ANegAlt & parity, ACoefData}.
  - Operands and address stay stable until AMacAck=1; then go to WAIT.
- WAIT:
  - On AMacVld, acc ← AMacRes and toggle parity.
  - If addr < AIdxLo + step, go to DONE. Otherwise addr ← addr − step, then go to ISSUE.
- DONE:
  - ARdy=1 and AResult ← acc (0 on error); AErr as latched.
  - Return to IDLE.
- Number of MAC operations = n; a request with AIdxHi == AIdxLo issues none.
- AReq while ABusy=1 is ignored. Requesters must hold AReq until ABusy rises.
- An AMacVld in IDLE, LOAD or ISSUE is ignored.
- AMacAck outside ISSUE is ignored.
- An address ≥ 0x11 reads coefficient 0 and is processed normally.

## Timing
- Reset values:
  - State IDLE.
  - ABusy=0, ARdy=0, AErr=0, AMacReq=0.
  - AResult, AMacA, AMacB, AMacC, acc = 0.
  - ACoefAddr=0.
- Reset mid-operation abandons the sequence immediately. Any MAC result still in flight afterwards is ignored.
- ABusy rises in the cycle after AReq is accepted.
- Latency from request to ARdy:
  - Zero terms: 3 cycles (IDLE→LOAD→DONE).
  - n terms: 3 + Σ(ack wait + MAC latency + 1) cycles.
- AMacReq is registered and asserted for at least 1 cycle. AMacAck in the first ISSUE cycle gives a one-cycle request.
- ACoefAddr changes only on state transitions, never while AMacReq=1.
- After DONE, the block is back in IDLE and can accept the next AReq in the following cycle.

## Test plan
- Single term: AIdxHi=AIdxLo=1 → ARdy after 3 cycles, AResult={0,7F,8000000}, no AMacReq.
- e^x tail: AIdxHi=3, AIdxLo=1, AStep2=0, y=1.0, MAC model with 2-cycle latency.
  - First issue: A={0,7C,AAAAAAA}, B=y, C={0,7E,8000000}.
  - Second issue: A=previous AMacRes, C={0,7F,8000000}.
  - Exactly 2 MAC operations; AResult equals the last AMacRes.
- sin series: AIdxHi=7, AIdxLo=1, AStep2=1, ANegAlt=1.
  - Addresses issued in order 7, 5, 3, 1.
  - Coefficient signs: addr 7 (LOAD) negative, addr 5 (C) positive, addr 3 (C) negative, addr 1 (C) positive.
  - 3 MAC operations.
- Backpressure: hold AMacAck=0 for 5 cycles.
  - AMacReq and operands stay stable.
  - A spurious AMacVld during ISSUE does not change acc.
- Error and overlap: AIdxHi=2, AIdxLo=5 → ARdy with AErr=1 and AResult=0. A second AReq while busy produces no second ARdy.
- Reset: deassert AResetHN during WAIT → all outputs at reset values at once. A late AMacVld after reset release is ignored.
